// File: rtl/board_led_spi_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : board_spi_pkg
// Purpose  : Shared constants and types for the board LED SPI receiver.
//            FRAME_BITS is shared with the board-state transmitter.
// Contents : FRAME_BITS, spi_rx_state_t, cnt_width() helper.
// Revision : 1.0 - initial release
// ============================================================================
package board_spi_pkg;

    localparam int FRAME_BITS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } spi_rx_state_t;

    // Counter must hold 0..bits inclusive so saturation at FRAME_BITS is visible.
    function automatic int cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_led_spi_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : board_led_spi_rx_if
// Purpose  : MCU-facing SPI pins plus the committed LED mask outputs.
// Signals  : sck, sdi, load       MCU -> FPGA (asynchronous to clk)
//            ledMask, frameValid, frameErr, busy   receiver outputs
// Modports : master = MCU / stimulus side, slave = receiver side.
// Revision : 1.0 - initial release
// ============================================================================
interface board_led_spi_rx_if #(
    parameter int FRAME_BITS = 64
);
    logic                  sck;
    logic                  sdi;
    logic                  load;
    logic [FRAME_BITS-1:0] ledMask;
    logic                  frameValid;
    logic                  frameErr;
    logic                  busy;

    modport master (
        output sck, sdi, load,
        input  ledMask, frameValid, frameErr, busy
    );

    modport slave (
        input  sck, sdi, load,
        output ledMask, frameValid, frameErr, busy
    );
endinterface
`default_nettype wire

// File: rtl/board_led_spi_rx_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Purpose  : SYNC_STAGES-deep flip-flop synchronizer with rise/fall detect
//            computed on the synchronized signal.
// Ports    : clk, reset (async, active-high), d (async input)
//            q (synchronized), rise / fall (one-clk pulses)
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise =  q & ~prev_q;
    assign fall = ~q &  prev_q;
endmodule
`default_nettype wire

// File: rtl/board_led_spi_rx.sv
`default_nettype none
// ============================================================================
// Module   : board_led_spi_rx
// Purpose  : Oversampled SPI receiver (MCU -> FPGA) for the 64-square LED
//            mask. A frame commits only if exactly FRAME_BITS sck rises
//            arrive while load is high; otherwise frameErr pulses.
// Ports    : clk   - system clock (>= 4x sck)
//            reset - asynchronous, active-high
//            bus   - board_led_spi_rx_if.slave (sck/sdi/load in,
//                    ledMask/frameValid/frameErr/busy out)
// Revision : 1.0 - initial release
// ============================================================================
module board_led_spi_rx #(
    parameter int FRAME_BITS  = board_spi_pkg::FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    board_led_spi_rx_if.slave       bus
);
    import board_spi_pkg::*;

    localparam int CNT_W = cnt_width(FRAME_BITS);

    // ------------------------------------------------------------------
    // Input synchronization. sdi goes through the same depth as sck so
    // the sampled data lines up with the detected sck rise.
    // ------------------------------------------------------------------
    logic sck_s, sck_rise, sck_fall;
    logic load_s, load_rise, load_fall;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic sdi_s;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.sck),
        .q     (sck_s),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.load),
        .q     (load_s),
        .rise  (load_rise),
        .fall  (load_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdi_sync_q <= '0;
        end else begin
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
        end
    end

    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

    // Level outputs and sck fall are not needed by the receiver.
    logic w_unused_ok;
    assign w_unused_ok = ^{sck_s, sck_fall, load_s};

    // ------------------------------------------------------------------
    // FSM, shift register, saturating counter, overflow flag, outputs
    // ------------------------------------------------------------------
    spi_rx_state_t          state_q,  state_d;
    logic [FRAME_BITS-1:0]  shreg_q,  shreg_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic                   ovf_q,    ovf_d;
    logic [FRAME_BITS-1:0]  mask_q,   mask_d;
    logic                   valid_q,  valid_d;
    logic                   err_q,    err_d;
    logic                   busy_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        mask_d  = mask_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load_rise) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            SHIFT: begin
                // A bit arriving together with load fall still belongs to
                // the frame: shift/count happen before leaving SHIFT.
                if (sck_rise) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], sdi_s};
                    if (cnt_q == CNT_W'(FRAME_BITS)) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (load_fall) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if ((cnt_q == CNT_W'(FRAME_BITS)) && !ovf_q) begin
                    mask_d  = shreg_q;
                    valid_d = 1'b1;
                end else begin
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            // Registered from next state so busy tracks SHIFT exactly.
            busy_q  <= (state_d == SHIFT);
        end
    end

    assign bus.ledMask    = mask_q;
    assign bus.frameValid = valid_q;
    assign bus.frameErr   = err_q;
    assign bus.busy       = busy_q;
endmodule
`default_nettype wire
